crc_param_engine: RTL and testbench
===================================

// Module: crc_param_engine
// PURPOSE
// - Parametrised CRC generator/checker. It is the successor to the fixed 16-bit serial CRC.
// - Width, polynomial, init value and output inversion are configurable.
// - Consumes DIN_W bits per accepted beat under a valid/ready handshake.
// - Closes the message on in_last and publishes a registered result with a 1-cycle crc_valid strobe.
// - Also flags the receive-side residue check (crc_ok).
// - Sits between the USB bit-unstuffer/stuffer and the packet FSMs; serves CRC5 tokens and CRC16 data.
// PARAMETERS
// - CRC_W   16       CRC register width (5 or 16 in use; legal 2..32)
// - POLY    16'h8005 generator polynomial, implicit x^CRC_W term omitted
// - INIT    16'hFFFF register value at reset/clear/start of message
// - XOROUT  16'hFFFF XORed onto the register to form crc (all-ones = invert)
// - RESIDUE 16'h800D raw register value after a good message plus its CRC
// - DIN_W   1        bits consumed per accepted beat (1..8)
// PORTS
// - clk        in   1      system clock, rising edge
// - n_rst      in   1      asynchronous reset, active low
// - clear      in   1      synchronous abort: register <= INIT, FSM -> IDLE
// - in_valid   in   1      in_data/in_last valid this cycle
// - in_ready   out  1      engine accepts a beat this cycle
// - in_data    in   DIN_W  message bits; in_data[0] processed first
// - in_last    in   1      accepted beat is the final beat of the message
// - crc        out  CRC_W  registered result = final register ^ XOROUT
// - crc_valid  out  1      1-cycle strobe: crc/crc_ok updated this cycle
// - crc_ok     out  1      final register == RESIDUE (valid with crc_valid, held after)
// - busy       out  1      message in progress (state ACCUM)
// BEHAVIOUR
// - Reset (n_rst=0, async):
//   - register = INIT; state IDLE.
//   - crc = INIT^XOROUT; crc_valid = 0; crc_ok = 0; busy = 0; in_ready = 1 after reset.
// - Per-bit step, applied to bits 0..DIN_W-1 in order within one cycle:
//   - fb = R[CRC_W-1] ^ bit; R = (R << 1) truncated to CRC_W; if fb, R ^= POLY.
// - Accept: a beat is consumed when in_valid && in_ready. There is no other way a beat enters.
// - States:
//   - IDLE: in_ready = 1.
//     - Accept with !in_last -> ACCUM.
//     - Accept with in_last -> DONE.
//   - ACCUM: in_ready = 1; busy = 1.
//     - Each accept updates R.
//     - Accept with in_last -> DONE.
//     - Idle cycles (in_valid = 0) hold R.
//   - DONE: lasts exactly 1 cycle; in_ready = 0.
//     - crc <= R^XOROUT; crc_ok <= (R==RESIDUE); crc_valid = 1.
//     - R <= INIT.
//     - Next state: IDLE.
// - Latency: crc_valid is asserted in the cycle after the in_last beat is accepted.
// - crc and crc_ok hold their values until the next DONE, clear, or reset.
// - clear has priority over everything, including an accept in the same cycle.
//   - The beat is dropped; R = INIT; state IDLE.
//   - crc_valid = 0 next cycle; crc and crc_ok are not altered.
// - clear while in DONE: the DONE update is suppressed and crc_valid stays 0.
// - Reset mid-message: immediate return to reset values; no partial result is published.
// - Zero-length message is not supported; in_last always rides on a data beat.
// - All outputs are registered or decoded from state only; no combinational path from in_* to outputs.
//   - Exception: none. in_ready depends on state only.
// STRUCTURE
// - Shared package usb_crc_pkg:
//   - typedef enum logic [1:0] {CRC_IDLE, CRC_ACCUM, CRC_DONE} crc_state_t
//   - localparams CRC5_POLY=5'h05, CRC5_INIT=5'h1F, CRC5_RESIDUE=5'h0C
//   - localparams CRC16_POLY=16'h8005, CRC16_INIT=16'hFFFF, CRC16_RESIDUE=16'h800D
// - Sub-module crc_step_comb (parameters CRC_W, POLY, DIN_W):
//   - combinational, unrolled DIN_W-bit update; input R, data; output next R.
//   - Top level holds the FSM, register and output registers.
// TESTING
// - CRC16 defaults, DIN_W=1:
//   - Single beat in_data=0, in_last=1 -> next cycle crc_valid=1, crc=16'h8004, crc_ok=0.
//   - Single beat in_data=1, in_last=1 -> crc=16'h0001.
// - CRC16, DIN_W=8, random 1..64-byte message:
//   - Feed the message, then the transmitted crc LSB-first as 2 beats -> crc_ok=1.
//   - Flip any one message bit -> crc_ok=0.
// - CRC5, DIN_W=1, 11-bit token: crc matches the bench reference model.
//   - Token plus its 5 CRC bits -> crc_ok=1 (residue 5'h0C).
// - Handshake:
//   - Random in_valid gaps during ACCUM -> same crc as a gapless run.
//   - in_ready=0 only in the DONE cycle; a beat offered then is not consumed and is accepted the next cycle.
// - clear coinciding with an in_last accept -> no crc_valid; crc holds its prior value.
//   - The next message computes from INIT.
// - n_rst pulse mid-ACCUM:
//   - outputs return to reset values asynchronously (crc=16'h0000 for defaults, busy=0).
//   - The next message computes from INIT.

Source files
------------

// File: rtl/usb_crc_pkg.sv
// Shared CRC definitions for the USB token and data paths: FSM state
// encoding and the polynomial/init/residue constants for CRC5 and CRC16.
package usb_crc_pkg;

    typedef enum logic [1:0] {
        CRC_IDLE,
        CRC_ACCUM,
        CRC_DONE
    } crc_state_t;

    localparam logic [4:0]  CRC5_POLY     = 5'h05;
    localparam logic [4:0]  CRC5_INIT     = 5'h1F;
    localparam logic [4:0]  CRC5_RESIDUE  = 5'h0C;

    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

endpackage

// File: rtl/crc_step_comb.sv
// Combinational CRC update: advances the register by DIN_W message bits in
// one cycle, bit 0 first, using an MSB-out shift with the data bit folded
// into the feedback term.
module crc_step_comb #(
    parameter int unsigned      CRC_W = 16,
    parameter logic [CRC_W-1:0] POLY  = 16'h8005,
    parameter int unsigned      DIN_W = 1
) (
    input  logic [CRC_W-1:0] cur_crc,
    input  logic [DIN_W-1:0] data,
    output logic [CRC_W-1:0] next_crc
);

    logic [CRC_W-1:0] work;

    // Unrolled chain of single-bit steps, one per data bit in arrival order
    always_comb begin
        work = cur_crc;
        for (int i = 0; i < int'(DIN_W); i++) begin
            if (work[CRC_W-1] ^ data[i]) begin
                work = {work[CRC_W-2:0], 1'b0} ^ POLY;
            end else begin
                work = {work[CRC_W-2:0], 1'b0};
            end
        end
        next_crc = work;
    end

endmodule

// File: rtl/crc_param_engine.sv
// Parametrised CRC generator/checker. Accepts DIN_W bits per handshake beat,
// closes the message on in_last and publishes crc/crc_ok with a one-cycle
// crc_valid strobe. The result is captured on the closing beat so that it is
// already on the outputs during the single DONE cycle that follows.
module crc_param_engine
    import usb_crc_pkg::*;
#(
    parameter int unsigned      CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = CRC16_POLY,
    parameter logic [CRC_W-1:0] INIT    = CRC16_INIT,
    parameter logic [CRC_W-1:0] XOROUT  = 16'hFFFF,
    parameter logic [CRC_W-1:0] RESIDUE = CRC16_RESIDUE,
    parameter int unsigned      DIN_W   = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIN_W-1:0] in_data,
    input  logic             in_last,
    output logic [CRC_W-1:0] crc,
    output logic             crc_valid,
    output logic             crc_ok,
    output logic             busy
);

    crc_state_t       state;
    crc_state_t       next_state;
    logic [CRC_W-1:0] crc_reg;
    logic [CRC_W-1:0] crc_step;
    logic             accept;
    logic             last_accept;

    // Handshake and status are pure state decodes so no input reaches an output
    assign in_ready    = (state != CRC_DONE);
    assign busy        = (state == CRC_ACCUM);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && in_last && !clear;

    crc_step_comb #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .DIN_W (DIN_W)
    ) u_step (
        .cur_crc  (crc_reg),
        .data     (in_data),
        .next_crc (crc_step)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= CRC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; clear overrides any transition, including a closing beat
    always_comb begin
        next_state = state;
        case (state)
            CRC_IDLE, CRC_ACCUM: begin
                if (accept) begin
                    next_state = in_last ? CRC_DONE : CRC_ACCUM;
                end
            end
            CRC_DONE: next_state = CRC_IDLE;
            default:  next_state = CRC_IDLE;
        endcase
        if (clear) begin
            next_state = CRC_IDLE;
        end
    end

    // Working register: restarts from INIT on clear and after every message
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_reg <= INIT;
        end else if (clear || (state == CRC_DONE)) begin
            crc_reg <= INIT;
        end else if (accept) begin
            crc_reg <= crc_step;
        end
    end

    // Published result: loaded from the closing beat, held until the next message
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc       <= INIT ^ XOROUT;
            crc_ok    <= 1'b0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= last_accept;
            if (last_accept) begin
                crc    <= crc_step ^ XOROUT;
                crc_ok <= (crc_step == RESIDUE);
            end
        end
    end

endmodule

// File: tb/tb_crc_param_engine.sv
// Scoreboard bench for crc_param_engine: three instances (CRC16 serial,
// CRC16 byte-wide, CRC5 serial) share data/last/clear/reset and have their
// own in_valid. Expected results are queued when a closing beat is issued
// and popped by a monitor whenever any instance strobes crc_valid.
module tb_crc_param_engine;
    import usb_crc_pkg::*;

    typedef struct {
        int          sel;
        logic [15:0] crc;
        logic        ok;
    } exp_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        clear;
    logic        in_last;
    logic [7:0]  in_data;
    logic        valid_v [3];

    logic [15:0] crc16a, crc16b;
    logic [4:0]  crc5;
    logic        rdy_a, rdy_b, rdy_c;
    logic        cv_a, cv_b, cv_c;
    logic        ok_a, ok_b, ok_c;
    logic        busy_a, busy_b, busy_c;

    logic [15:0] crc_v  [3];
    logic        rdy_v  [3];
    logic        cv_v   [3];
    logic        ok_v   [3];
    logic        busy_v [3];

    exp_t        exp_q [$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  msg [0:65];

    always #5 clk = ~clk;

    crc_param_engine #(
        .CRC_W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT),
        .XOROUT(16'hFFFF), .RESIDUE(CRC16_RESIDUE), .DIN_W(1)
    ) dut_a (
        .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(valid_v[0]),
        .in_ready(rdy_a), .in_data(in_data[0:0]), .in_last(in_last),
        .crc(crc16a), .crc_valid(cv_a), .crc_ok(ok_a), .busy(busy_a)
    );

    crc_param_engine #(
        .CRC_W(16), .POLY(CRC16_POLY), .INIT(CRC16_INIT),
        .XOROUT(16'hFFFF), .RESIDUE(CRC16_RESIDUE), .DIN_W(8)
    ) dut_b (
        .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(valid_v[1]),
        .in_ready(rdy_b), .in_data(in_data), .in_last(in_last),
        .crc(crc16b), .crc_valid(cv_b), .crc_ok(ok_b), .busy(busy_b)
    );

    crc_param_engine #(
        .CRC_W(5), .POLY(CRC5_POLY), .INIT(CRC5_INIT),
        .XOROUT(5'h1F), .RESIDUE(CRC5_RESIDUE), .DIN_W(1)
    ) dut_c (
        .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(valid_v[2]),
        .in_ready(rdy_c), .in_data(in_data[0:0]), .in_last(in_last),
        .crc(crc5), .crc_valid(cv_c), .crc_ok(ok_c), .busy(busy_c)
    );

    // Gather the three instances' outputs into arrays indexed by instance
    always_comb begin
        crc_v[0]  = crc16a;  crc_v[1]  = crc16b;  crc_v[2]  = {11'd0, crc5};
        rdy_v[0]  = rdy_a;   rdy_v[1]  = rdy_b;   rdy_v[2]  = rdy_c;
        cv_v[0]   = cv_a;    cv_v[1]   = cv_b;    cv_v[2]   = cv_c;
        ok_v[0]   = ok_a;    ok_v[1]   = ok_b;    ok_v[2]   = ok_c;
        busy_v[0] = busy_a;  busy_v[1] = busy_b;  busy_v[2] = busy_c;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic expect_result(input int sel, input logic [15:0] crc, input logic ok);
        exp_t e;
        e.sel = sel;
        e.crc = crc;
        e.ok  = ok;
        exp_q.push_back(e);
    endtask

    // Reference: MSB-out register, data bit XORed into the feedback, bit 0 first
    function automatic logic [15:0] model_step(input int w, input logic [15:0] poly,
                                               input logic [15:0] r, input logic [15:0] data,
                                               input int nbits);
        logic [15:0] mask;
        logic        fb;
        mask = 16'((32'h1 << w) - 1);
        for (int i = 0; i < nbits; i++) begin
            fb = r[w-1] ^ data[i];
            r  = (r << 1) & mask;
            if (fb) r = r ^ poly;
        end
        return r;
    endfunction

    // Offer one beat to instance sel and hold it until accepted (bounded)
    task automatic apply_stimulus(input int sel, input logic [7:0] data, input logic last,
                                  input logic with_clear, output int stall);
        logic rdy;
        rdy   = 1'b0;
        stall = 0;
        valid_v[sel] = 1'b1;
        in_data      = data;
        in_last      = last;
        clear        = with_clear;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rdy = rdy_v[sel];
            @(posedge clk);
            #1;
            if (rdy) break;
            stall++;
        end
        valid_v[sel] = 1'b0;
        in_last      = 1'b0;
        clear        = 1'b0;
        if (!rdy) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: dut=%0d in_ready=0 expected=1", sel);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial message of n bits on a 1-bit instance, optional random gaps
    task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input int max_gap);
        int stall;
        for (int i = 0; i < n; i++) begin
            apply_stimulus(sel, {7'd0, bits[i]}, (i == n - 1), 1'b0, stall);
            if (max_gap > 0 && i != n - 1) idle_cycles($urandom_range(0, max_gap));
        end
    endtask

    // Byte message msg[0..n-1] on the byte-wide instance
    task automatic send_bytes(input int n);
        int stall;
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1, msg[i], (i == n - 1), 1'b0, stall);
        end
    endtask

    function automatic logic [15:0] model_bytes(input int n);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < n; i++) r = model_step(16, 16'h8005, r, {8'd0, msg[i]}, 8);
        return r;
    endfunction

    // Scoreboard monitor: every crc_valid strobe must match the oldest expectation
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (cv_v[s] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_valid: dut=%0d crc=%0h expected no result", s, crc_v[s]);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output($sformatf("dut%0d_source", s), 32'(s), 32'(mon_e.sel));
                    check_output($sformatf("dut%0d_crc", s), {16'd0, crc_v[s]}, {16'd0, mon_e.crc});
                    check_output($sformatf("dut%0d_crc_ok", s), {31'd0, ok_v[s]}, {31'd0, mon_e.ok});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] r, c, t, prev, w;
        int          stall, n, b, k;

        n_rst   = 1'b0;
        clear   = 1'b0;
        in_last = 1'b0;
        in_data = 8'd0;
        for (int i = 0; i < 3; i++) valid_v[i] = 1'b0;

        // Reset values while n_rst is held low
        #12;
        check_output("rst_crc16", {16'd0, crc16a}, 32'h0000);
        check_output("rst_crc5", {27'd0, crc5}, 32'h00);
        check_output("rst_valid", {31'd0, cv_a}, 32'd0);
        check_output("rst_ok", {31'd0, ok_a}, 32'd0);
        check_output("rst_busy", {31'd0, busy_a}, 32'd0);
        check_output("rst_ready", {31'd0, rdy_a}, 32'd1);
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycles(1);

        // Single-bit messages; second is offered during DONE and must wait a cycle
        expect_result(0, 16'h8004, 1'b0);
        apply_stimulus(0, 8'h00, 1'b1, 1'b0, stall);
        check_output("latency_valid", {31'd0, cv_a}, 32'd1);
        check_output("done_ready", {31'd0, rdy_a}, 32'd0);
        expect_result(0, 16'h0001, 1'b0);
        apply_stimulus(0, 8'h01, 1'b1, 1'b0, stall);
        check_output("done_stall", 32'(stall), 32'd1);
        idle_cycles(2);

        // Same byte serially, gapless then with random idle gaps
        r = model_step(16, 16'h8005, 16'hFFFF, 16'h00A5, 8);
        expect_result(0, r ^ 16'hFFFF, r == 16'h800D);
        send_bits(0, 16'h00A5, 8, 0);
        idle_cycles(2);
        expect_result(0, r ^ 16'hFFFF, r == 16'h800D);
        send_bits(0, 16'h00A5, 8, 3);
        prev = r ^ 16'hFFFF;
        idle_cycles(2);

        // clear on the closing beat: nothing published, prior crc kept
        apply_stimulus(0, 8'h01, 1'b0, 1'b0, stall);
        apply_stimulus(0, 8'h00, 1'b1, 1'b1, stall);
        idle_cycles(2);
        check_output("clear_hold_crc", {16'd0, crc16a}, {16'd0, prev});
        expect_result(0, 16'h8004, 1'b0);
        apply_stimulus(0, 8'h00, 1'b1, 1'b0, stall);
        idle_cycles(2);

        // Asynchronous reset in the middle of a message
        apply_stimulus(0, 8'h01, 1'b0, 1'b0, stall);
        apply_stimulus(0, 8'h00, 1'b0, 1'b0, stall);
        check_output("accum_busy", {31'd0, busy_a}, 32'd1);
        #2 n_rst = 1'b0;
        #1;
        check_output("midrst_crc", {16'd0, crc16a}, 32'h0000);
        check_output("midrst_busy", {31'd0, busy_a}, 32'd0);
        check_output("midrst_ready", {31'd0, rdy_a}, 32'd1);
        check_output("midrst_valid", {31'd0, cv_a}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycles(1);
        expect_result(0, 16'h0001, 1'b0);
        apply_stimulus(0, 8'h01, 1'b1, 1'b0, stall);
        idle_cycles(2);

        // Byte-wide CRC16: message, message + crc (residue), corrupted message + crc
        for (int trial = 0; trial < 3; trial++) begin
            n = (trial == 0) ? 1 : $urandom_range(1, 64);
            for (int i = 0; i < n; i++) msg[i] = 8'($urandom_range(0, 255));
            r = model_bytes(n);
            c = r ^ 16'hFFFF;
            expect_result(1, c, r == 16'h800D);
            send_bytes(n);
            idle_cycles(1);
            // Transmitted field is the crc bit-reversed, so crc[15] goes out first
            for (int i = 0; i < 16; i++) t[i] = c[15 - i];
            msg[n]     = t[7:0];
            msg[n + 1] = t[15:8];
            expect_result(1, 16'h7FF2, 1'b1);
            send_bytes(n + 2);
            idle_cycles(1);
            b = $urandom_range(0, n - 1);
            k = $urandom_range(0, 7);
            msg[b] = msg[b] ^ 8'(1 << k);
            r = model_bytes(n + 2);
            expect_result(1, r ^ 16'hFFFF, 1'b0);
            send_bytes(n + 2);
            idle_cycles(2);
        end

        // CRC5 tokens: all-zero token has a known crc of 5'h08
        expect_result(2, 16'h0008, 1'b0);
        send_bits(2, 16'h0000, 11, 0);
        idle_cycles(1);
        expect_result(2, 16'h0013, 1'b1);
        send_bits(2, 16'h1000, 16, 0);
        idle_cycles(1);
        r = model_step(5, 16'h0005, 16'h001F, 16'h04A5, 11);
        c = r ^ 16'h001F;
        expect_result(2, c, r == 16'h000C);
        send_bits(2, 16'h04A5, 11, 2);
        idle_cycles(1);
        w = 16'h04A5;
        for (int i = 0; i < 5; i++) w[11 + i] = c[4 - i];
        expect_result(2, 16'h0013, 1'b1);
        send_bits(2, w, 16, 0);
        idle_cycles(5);

        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
